sprite_palette_bank: RTL and testbench
======================================

Name: sprite_palette_bank

Overview:
- Multi-bank, runtime-writable colour lookup table for sprite rendering.
- Converts a per-pixel palette index plus bank select into 12-bit RGB (4 bits per channel, default), with a transparency flag.
- Two-stage registered pipeline between the sprite ROM/index stage and the VGA colour mux.
- Adds bank-cycling animation driven by a frame strobe, so sprites can recolour or flash without ROM changes.

Parameters:
- INDEX_W, 4, palette index width; each bank holds 2**INDEX_W entries.
- CH_W, 4, bits per colour channel.
- NUM_BANKS, 4, number of palettes; power of two, at least 2.
- TRANSPARENT_INDEX, 0, index reported as transparent.
- ANIM_PERIOD, 8, frame strobes per animation step; at least 1.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- pix_valid  in  1  lookup request this cycle
- pix_index  in  INDEX_W  palette index
- pix_bank  in  $clog2(NUM_BANKS)  requested bank
- wr_en  in  1  palette write strobe
- wr_bank  in  $clog2(NUM_BANKS)  write bank
- wr_index  in  INDEX_W  write entry
- wr_color  in  3*CH_W  {r,g,b} write data
- anim_en  in  1  enable bank cycling
- frame_strobe  in  1  one-cycle pulse per frame
- dim  in  2  brightness shift (used only with the optional feature)
- out_valid  out  1  colour valid
- red, green, blue  out  CH_W each  colour
- out_transparent  out  1  index equalled TRANSPARENT_INDEX
- anim_offset  out  $clog2(NUM_BANKS)  current bank offset

Behaviour:
- Reset is asynchronous and active-low, and is honoured mid-operation. While reset_n=0:
  - out_valid, red, green, blue, out_transparent and anim_offset are all 0.
  - The frame counter is 0 and both pipeline valid bits are cleared.
  - Every bank loads the default palette: entry 1 = {F,F,F}; all other entries = {F,0,D} (chroma-key magenta).
- Effective bank = (pix_bank + anim_offset) mod NUM_BANKS. Computed at the sampling edge, so natural wrap is required.
- Stage 1: on the edge where pix_valid=1, register the effective bank, the index, and the transparency compare.
- Stage 2: on the next edge, perform the array read and register the colour.
  - out_valid asserts exactly 2 edges after pix_valid is sampled.
  - Throughput is 1 lookup per cycle; there is no backpressure.
  - Outputs hold their last value while out_valid=0.
- Writes:
  - wr_en commits wr_color to [wr_bank][wr_index] on the sampling edge.
  - The array read is unregistered from stage-1 state, so a lookup sampled at edge k sees every write sampled at an edge ≤ k+1.
  - A write to an entry read by the same lookup at edge k+1 therefore returns the new colour.
  - Writes to index TRANSPARENT_INDEX are stored normally; out_transparent still asserts for that index.
- Animation:
  - When anim_en=0, frame_cnt and anim_offset clear to 0 synchronously.
  - When anim_en=1, each frame_strobe increments frame_cnt. When a strobe arrives with frame_cnt=ANIM_PERIOD-1:
    - frame_cnt becomes 0;
    - anim_offset increments mod NUM_BANKS (NUM_BANKS-1 wraps to 0).
  - A new offset applies to lookups sampled on the following edge onward; lookups already in flight keep their bank.
  - frame_strobe held high increments the counter every cycle; no edge detection is required.
- Simultaneous events:
  - Write and lookup on the same cycle: both proceed.
  - anim_en falling on a strobe edge: the clear wins.
- Palette storage is flip-flop based, because async reset must preload it.

Optional Feature:
- Macro SPRITE_PALETTE_DIM_EN.
- Defined: stage 2 outputs each channel as colour >> dim, with the shift amount sampled alongside pix_valid in stage 1.
  - dim=0 leaves the colour unchanged.
  - dim=3 on F gives 1.
  - out_transparent is unaffected.
- Undefined: dim is ignored and colours pass unmodified; latency is identical in both builds.

Test Plan:
- Reset defaults: release reset, then lookup bank 0, index 1 → 2 cycles later out_valid=1, {F,F,F}. Index 0 → {F,0,D}, out_transparent=1. Index 5, bank 3 → {F,0,D}, out_transparent=0.
- Write then read with bypass:
  - Write bank 2, index 7 = {1,2,3} at edge k+1 while bank 2, index 7 is looked up at edge k → result {1,2,3}.
  - Same write issued at edge k+2 → result {F,0,D}.
- Back-to-back stream: lookups of indices 0..15 on 16 consecutive cycles → 16 consecutive out_valid cycles, in order, 2-cycle latency.
- Animation wrap:
  - anim_en=1, ANIM_PERIOD=8, 32 strobes → anim_offset steps 1,2,3,0.
  - With pix_bank=3 and offset 1, the lookup uses bank 0.
  - Dropping anim_en → offset 0 the next cycle.
- Mid-stream reset: assert reset_n=0 with 2 lookups in flight and bank 1 entry 4 rewritten → outputs 0 immediately, no out_valid after release, entry 4 reads {F,0,D}.
- With SPRITE_PALETTE_DIM_EN: dim=2 on {F,F,F} → {3,3,3}. Without the macro, same stimulus → {F,F,F}.

Source files
------------

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: banked RGB palette with a two-stage lookup pipeline and frame-driven bank cycling.
// Optional build macro SPRITE_PALETTE_DIM_EN adds a per-pixel brightness right-shift in stage 2.
module sprite_palette_bank #(
  parameter int INDEX_W           = 4,
  parameter int CH_W              = 4,
  parameter int NUM_BANKS         = 4,
  parameter int TRANSPARENT_INDEX = 0,
  parameter int ANIM_PERIOD       = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         pix_valid,
  input  logic [INDEX_W-1:0]           pix_index,
  input  logic [$clog2(NUM_BANKS)-1:0] pix_bank,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
  input  logic [INDEX_W-1:0]           wr_index,
  input  logic [3*CH_W-1:0]            wr_color,
  input  logic                         anim_en,
  input  logic                         frame_strobe,
  input  logic [1:0]                   dim,
  output logic                         out_valid,
  output logic [CH_W-1:0]              red,
  output logic [CH_W-1:0]              green,
  output logic [CH_W-1:0]              blue,
  output logic                         out_transparent,
  output logic [$clog2(NUM_BANKS)-1:0] anim_offset
);

  localparam int BANK_W  = $clog2(NUM_BANKS);
  localparam int ENTRIES = 2**INDEX_W;
  localparam int COLOR_W = 3*CH_W;
  localparam int CNT_W   = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

  localparam logic [COLOR_W-1:0] WHITE = {COLOR_W{1'b1}};
  localparam logic [CH_W-1:0]    KEY_B = CH_W'(13);
  localparam logic [COLOR_W-1:0] KEY   = {{CH_W{1'b1}}, {CH_W{1'b0}}, KEY_B};

  // Flip-flop storage so the async reset can preload the default palette.
  logic [COLOR_W-1:0] pal [NUM_BANKS][ENTRIES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int i = 0; i < ENTRIES; i++)
          pal[b][i] <= (i == 1) ? WHITE : KEY;
    end else if (wr_en) begin
      pal[wr_bank][wr_index] <= wr_color;
    end
  end

  logic [CNT_W-1:0] frame_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt   <= '0;
      anim_offset <= '0;
    end else if (!anim_en) begin
      frame_cnt   <= '0;
      anim_offset <= '0;
    end else if (frame_strobe) begin
      if (frame_cnt == CNT_W'(ANIM_PERIOD - 1)) begin
        frame_cnt   <= '0;
        anim_offset <= anim_offset + BANK_W'(1);
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  logic               s1_valid;
  logic               s1_transp;
  logic [BANK_W-1:0]  s1_bank;
  logic [INDEX_W-1:0] s1_index;
`ifdef SPRITE_PALETTE_DIM_EN
  logic [1:0]         s1_dim;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_transp <= 1'b0;
      s1_bank   <= '0;
      s1_index  <= '0;
`ifdef SPRITE_PALETTE_DIM_EN
      s1_dim    <= '0;
`endif
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_bank   <= pix_bank + anim_offset;
        s1_index  <= pix_index;
        s1_transp <= (pix_index == INDEX_W'(TRANSPARENT_INDEX));
`ifdef SPRITE_PALETTE_DIM_EN
        s1_dim    <= dim;
`endif
      end
    end
  end

`ifndef SPRITE_PALETTE_DIM_EN
  logic unused_dim;
  assign unused_dim = ^dim;
`endif

  // A write landing on the same edge as the stage-2 read must be visible to it.
  logic [COLOR_W-1:0] rd_color;

  always_comb begin
    rd_color = pal[s1_bank][s1_index];
    if (wr_en && (wr_bank == s1_bank) && (wr_index == s1_index))
      rd_color = wr_color;
  end

  logic [CH_W-1:0] rd_r, rd_g, rd_b;

`ifdef SPRITE_PALETTE_DIM_EN
  assign rd_r = rd_color[COLOR_W-1 -: CH_W] >> s1_dim;
  assign rd_g = rd_color[2*CH_W-1 -: CH_W] >> s1_dim;
  assign rd_b = rd_color[CH_W-1:0] >> s1_dim;
`else
  assign rd_r = rd_color[COLOR_W-1 -: CH_W];
  assign rd_g = rd_color[2*CH_W-1 -: CH_W];
  assign rd_b = rd_color[CH_W-1:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid       <= 1'b0;
      red             <= '0;
      green           <= '0;
      blue            <= '0;
      out_transparent <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        red             <= rd_r;
        green           <= rd_g;
        blue            <= rd_b;
        out_transparent <= s1_transp;
      end
    end
  end

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Testbench for sprite_palette_bank: behavioural palette model checked every cycle, plus literal directed checks.
module tb_sprite_palette_bank;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic [3:0]  pix_index = '0;
  logic [1:0]  pix_bank = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_bank = '0;
  logic [3:0]  wr_index = '0;
  logic [11:0] wr_color = '0;
  logic        anim_en = 1'b0;
  logic        frame_strobe = 1'b0;
  logic [1:0]  dim = '0;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        out_transparent;
  logic [1:0]  anim_offset;

  sprite_palette_bank dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_index(pix_index),
    .pix_bank(pix_bank), .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index),
    .wr_color(wr_color), .anim_en(anim_en), .frame_strobe(frame_strobe), .dim(dim),
    .out_valid(out_valid), .red(red), .green(green), .blue(blue),
    .out_transparent(out_transparent), .anim_offset(anim_offset)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: palette array, frame/offset counters, and a queue of lookups awaiting their read.
  typedef struct { int bank; int idx; int dm; } look_t;
  look_t      q[$];
  logic [11:0] mpal [4][16];
  int m_cnt, m_off;
  int e_valid, e_r, e_g, e_b, e_t;

  always @(posedge clk or negedge reset_n) begin
    look_t rec;
    logic [11:0] c;
    if (!reset_n) begin
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < 16; i++)
          mpal[b][i] = (i == 1) ? 12'hFFF : 12'hF0D;
      m_cnt = 0; m_off = 0; q.delete();
      e_valid = 0; e_r = 0; e_g = 0; e_b = 0; e_t = 0;
    end else begin
      if (wr_en) mpal[wr_bank][wr_index] = wr_color;
      e_valid = 0;
      if (q.size() > 0) begin
        rec = q.pop_front();
        c = mpal[rec.bank][rec.idx];
        e_valid = 1;
        e_r = int'(c[11:8]); e_g = int'(c[7:4]); e_b = int'(c[3:0]);
`ifdef SPRITE_PALETTE_DIM_EN
        e_r = e_r >> rec.dm; e_g = e_g >> rec.dm; e_b = e_b >> rec.dm;
`endif
        e_t = (rec.idx == 0) ? 1 : 0;
      end
      if (pix_valid) begin
        rec.bank = (int'(pix_bank) + m_off) % 4;
        rec.idx  = int'(pix_index);
        rec.dm   = int'(dim);
        q.push_back(rec);
      end
      if (!anim_en) begin
        m_cnt = 0; m_off = 0;
      end else if (frame_strobe) begin
        m_cnt++;
        if (m_cnt == 8) begin m_cnt = 0; m_off = (m_off + 1) % 4; end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_rgb", int'({red, green, blue}), 0);
      chk("rst_transp", out_transparent, 0);
      chk("rst_offset", anim_offset, 0);
    end else begin
      chk("out_valid", out_valid, e_valid);
      chk("anim_offset", anim_offset, m_off);
      chk("red", red, e_r);
      chk("green", green, e_g);
      chk("blue", blue, e_b);
      chk("transparent", out_transparent, e_t);
    end
  end

  int vcnt = 0;
  always @(negedge clk) if (out_valid) vcnt++;

  task automatic lookup_check(input int b, input int i, input int exp_rgb, input int exp_t, input string name);
    pix_valid = 1'b1; pix_bank = 2'(b); pix_index = 4'(i);
    @(negedge clk); pix_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_rgb"}, int'({red, green, blue}), exp_rgb);
    chk({name, "_transp"}, out_transparent, exp_t);
  endtask

  task automatic write_entry(input int b, input int i, input int c);
    wr_en = 1'b1; wr_bank = 2'(b); wr_index = 4'(i); wr_color = 12'(c);
    @(negedge clk); wr_en = 1'b0;
  endtask

  initial begin
    int v0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    lookup_check(0, 1, 'hFFF, 0, "def_white");
    lookup_check(0, 0, 'hF0D, 1, "def_key_t");
    lookup_check(3, 5, 'hF0D, 0, "def_key");

    // Write two edges after the lookup is sampled: too late for it.
    pix_valid = 1'b1; pix_bank = 2'd2; pix_index = 4'd9;
    @(negedge clk); pix_valid = 1'b0;
    @(negedge clk);
    chk("late_write_rgb", int'({red, green, blue}), 'hF0D);
    write_entry(2, 9, 'h123);

    // Write one edge after the lookup: bypass returns the new colour.
    pix_valid = 1'b1; pix_bank = 2'd2; pix_index = 4'd7;
    @(negedge clk); pix_valid = 1'b0;
    wr_en = 1'b1; wr_bank = 2'd2; wr_index = 4'd7; wr_color = 12'h123;
    @(negedge clk); wr_en = 1'b0;
    chk("bypass_rgb", int'({red, green, blue}), 'h123);
    lookup_check(2, 9, 'h123, 0, "late_write_after");

    write_entry(0, 3, 'hABC);
    write_entry(1, 4, 'h555);
    write_entry(2, 0, 'h777);
    lookup_check(2, 0, 'h777, 1, "transp_written");

    repeat (2) @(negedge clk);
    v0 = vcnt;
    for (int i = 0; i < 16; i++) begin
      pix_valid = 1'b1; pix_bank = 2'd0; pix_index = 4'(i);
      @(negedge clk);
    end
    pix_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("stream_count", vcnt - v0, 16);

    anim_en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      frame_strobe = 1'b1;
      @(negedge clk); frame_strobe = 1'b0;
      if (i % 8 == 0) chk("anim_step", anim_offset, (i / 8) % 4);
      @(negedge clk);
    end
    frame_strobe = 1'b1;
    repeat (8) @(negedge clk);
    frame_strobe = 1'b0;
    chk("anim_held_strobe", anim_offset, 1);
    lookup_check(3, 3, 'hABC, 0, "anim_bank_wrap");
    anim_en = 1'b0;
    @(negedge clk);
    chk("anim_clear", anim_offset, 0);

    // Reset with two lookups in flight.
    pix_valid = 1'b1; pix_bank = 2'd1; pix_index = 4'd4;
    @(negedge clk); pix_index = 4'd5;
    @(negedge clk); pix_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_rgb", int'({red, green, blue}), 0);
    chk("midrst_transp", out_transparent, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    v0 = vcnt;
    repeat (3) @(negedge clk);
    chk("midrst_no_valid", vcnt - v0, 0);
    lookup_check(1, 4, 'hF0D, 0, "midrst_entry");

    dim = 2'd2;
`ifdef SPRITE_PALETTE_DIM_EN
    lookup_check(0, 1, 'h333, 0, "dim2");
`else
    lookup_check(0, 1, 'hFFF, 0, "dim_ignored");
`endif
    dim = 2'd0;

    for (int n = 0; n < 600; n++) begin
      pix_valid    = ($urandom_range(0, 3) != 0);
      pix_bank     = 2'($urandom_range(0, 3));
      pix_index    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      wr_en        = ($urandom_range(0, 3) == 0);
      wr_bank      = 2'($urandom_range(0, 3));
      wr_index     = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      wr_color     = 12'($urandom_range(0, 4095));
      anim_en      = ($urandom_range(0, 31) != 0);
      frame_strobe = ($urandom_range(0, 1) != 0);
      dim          = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    pix_valid = 1'b0; wr_en = 1'b0; frame_strobe = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
